// File: rtl/phase_sequencer_if.sv
// Control-decoder handshake bundle: run/step/resume/halt in, phase and status out.
// master = controller side, slave = phase_sequencer.
interface phase_sequencer_if #(
  parameter int ICNT_W = 16
);
  logic              run;
  logic              step_req;
  logic              resume;
  logic              halt;
  logic [2:0]        phase;
  logic              running;
  logic              halted;
  logic              step_ack;
  logic [ICNT_W-1:0] icount;

  modport master (
    output run, step_req, resume, halt,
    input  phase, running, halted, step_ack, icount
  );

  modport slave (
    input  run, step_req, resume, halt,
    output phase, running, halted, step_ack, icount
  );
endinterface

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer (IDLE/RUN/STEP/HALT); retired-instruction counter built only with PHASE_SEQ_ICOUNT_EN.
// All outputs registered, one-edge response; requests outside their accepting state are dropped, never queued.
module phase_sequencer #(
  parameter int ICNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  phase_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e     state_q;
  logic [2:0] phase_q;
  logic       running_q;
  logic       halted_q;
  logic       step_ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= 3'd0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      step_ack_q <= 1'b0;
    end else begin
      step_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          phase_q <= 3'd0;
          if (bus.run) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end else if (bus.step_req) begin
            state_q   <= S_STEP;
            running_q <= 1'b1;
          end
        end
        S_RUN, S_STEP: begin
          // The halting instruction retires at phase 4; phases 5..7 are skipped.
          if (phase_q == 3'd4 && bus.halt) begin
            state_q    <= S_HALT;
            phase_q    <= 3'd0;
            running_q  <= 1'b0;
            halted_q   <= 1'b1;
            step_ack_q <= (state_q == S_STEP);
          end else if (phase_q == 3'd7) begin
            phase_q <= 3'd0;
            if (state_q == S_STEP || !bus.run) begin
              state_q   <= S_IDLE;
              running_q <= 1'b0;
            end
            step_ack_q <= (state_q == S_STEP);
          end else begin
            phase_q <= phase_q + 3'd1;
          end
        end
        S_HALT: begin
          if (bus.resume) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          phase_q   <= 3'd0;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase    = phase_q;
  assign bus.running  = running_q;
  assign bus.halted   = halted_q;
  assign bus.step_ack = step_ack_q;

`ifdef PHASE_SEQ_ICOUNT_EN
  logic [ICNT_W-1:0] icount_q;
  logic [ICNT_W-1:0] icount_d;
  logic              retire_d;

  always_comb begin
    retire_d = running_q && (phase_q == 3'd7 || (phase_q == 3'd4 && bus.halt));
    icount_d = retire_d ? icount_q + 1'b1 : icount_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icount_q <= '0;
    end else begin
      icount_q <= icount_d;
    end
  end

  assign bus.icount = icount_q;
`else
  assign bus.icount = '0;
`endif

endmodule
